// File: rtl/rom_stream_reader.sv
// Burst reader in front of a combinational ROM: fetches consecutive words from a
// programmed start address and presents them on a valid/ready stream, stalling on backpressure.
module rom_stream_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_read_en,
  output logic              rom_ce,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // A zero length request means the whole ROM, which needs one extra counter bit.
  localparam logic [ADDR_W:0] FULL_DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] REM_ONE    = (ADDR_W+1)'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                done_q, done_d;
  logic                load;

  // A ROM read is only issued when the output register is free or being emptied this cycle.
  assign load        = (state_q == FETCH) && (!out_valid_q || out_ready);
  assign rom_ce      = load;
  assign rom_read_en = load;
  assign rom_address = addr_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          addr_d  = start_addr;
          rem_d   = (length == '0) ? FULL_DEPTH : {1'b0, length};
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (abort) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else if (load) begin
          out_data_d  = rom_data;
          out_valid_d = 1'b1;
          addr_d      = addr_q + ADDR_W'(1);
          rem_d       = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        // The final word is still in the output register; finish once it is taken.
        if (abort) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench for rom_stream_reader: expected fetch addresses and stream words are
// queued when a burst is issued and popped by an independent negedge monitor.
module tb_rom_stream_reader;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] length = '0;
  logic [AW-1:0] rom_address;
  logic          rom_read_en;
  logic          rom_ce;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [256];
  assign rom_data = mem[rom_address];

  rom_stream_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .length(length), .abort(abort), .rom_address(rom_address),
    .rom_read_en(rom_read_en), .rom_ce(rom_ce), .rom_data(rom_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int ready_mode = 0;
  int pat = 0;
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consumer: 0 = always ready, 1 = random, 2 = repeating 1,0,0
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 99) < 65);
        default: begin
          out_ready = (pat == 0);
          pat = (pat + 1) % 3;
        end
      endcase
    end
  end

  logic          p_ok = 1'b0;
  logic          p_valid, p_ready, p_busy, p_ce, p_abort;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data;

  always @(negedge clk) begin
    if (!reset_n) begin
      check("ce_in_reset", {31'd0, rom_ce}, 32'd0);
      p_ok = 1'b0;
    end else begin
      if (p_ok && p_valid && !p_ready && !p_abort) begin
        check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
        check("stall_hold_data", {24'd0, out_data}, {24'd0, p_data});
      end
      if (p_ok && p_busy && busy && !p_ce)
        check("addr_stable", {24'd0, rom_address}, {24'd0, p_addr});
      if (out_valid && !out_ready)
        check("ce_in_stall", {31'd0, rom_ce}, 32'd0);
      if (rom_ce && !abort) begin
        if (exp_addr_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_fetch: rom_ce high at addr 0x%0h, required no fetch", rom_address);
        end else begin
          check("fetch_addr", {24'd0, rom_address}, {24'd0, exp_addr_q.pop_front()});
          check("read_en", {31'd0, rom_read_en}, 32'd1);
        end
      end
      if (out_valid && out_ready && !abort) begin
        hs_cnt++;
        if (exp_data_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got 0x%0h, required no word", out_data);
        end else begin
          check("out_data", {24'd0, out_data}, {24'd0, exp_data_q.pop_front()});
        end
      end
      if (done) begin
        done_cnt++;
        check("busy_at_done", {31'd0, busy}, 32'd0);
      end
      p_ok    = 1'b1;
      p_valid = out_valid;
      p_ready = out_ready;
      p_busy  = busy;
      p_ce    = rom_ce;
      p_abort = abort;
      p_addr  = rom_address;
      p_data  = out_data;
    end
  end

  // Reference: a burst reads length words (0 = 256) from consecutive addresses modulo 256.
  task automatic issue(input logic [AW-1:0] sa, input logic [AW-1:0] len);
    int n;
    logic [AW-1:0] a;
    n = (len == 0) ? 256 : int'(len);
    for (int i = 0; i < n; i++) begin
      a = sa + AW'(i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(mem[a]);
    end
    start = 1'b1;
    start_addr = sa;
    length = len;
    tick();
    start = 1'b0;
  endtask

  task automatic flush();
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  task automatic finish_burst(input string name, input int d0);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: busy still 1 after 3000 cycles, required 0", name);
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    tick();
    tick();
    check({name, "_done_count"}, done_cnt - d0, 32'd1);
    check({name, "_addr_left"}, exp_addr_q.size(), 32'd0);
    check({name, "_data_left"}, exp_data_q.size(), 32'd0);
    flush();
  endtask

  // mem[i] = i ^ 0xA5, start 0x10, length 4: words B5, B4, B7, B6 from E0+1 to E0+4.
  task automatic timed_basic(input string name);
    int d0;
    ready_mode = 0;
    tick();
    d0 = done_cnt;
    issue(8'h10, 8'd4);
    check({name, "_e0_ce"}, {31'd0, rom_ce}, 32'd1);
    check({name, "_e0_addr"}, {24'd0, rom_address}, 32'h10);
    check({name, "_e0_valid"}, {31'd0, out_valid}, 32'd0);
    check({name, "_e0_busy"}, {31'd0, busy}, 32'd1);
    tick();
    check({name, "_e1_valid"}, {31'd0, out_valid}, 32'd1);
    check({name, "_e1_data"}, {24'd0, out_data}, 32'hB5);
    tick();
    tick();
    tick();
    check({name, "_e4_valid"}, {31'd0, out_valid}, 32'd1);
    check({name, "_e4_data"}, {24'd0, out_data}, 32'hB6);
    check({name, "_e4_done"}, {31'd0, done}, 32'd0);
    tick();
    check({name, "_e5_done"}, {31'd0, done}, 32'd1);
    check({name, "_e5_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_e5_valid"}, {31'd0, out_valid}, 32'd0);
    check({name, "_e5_ce"}, {31'd0, rom_ce}, 32'd0);
    tick();
    check({name, "_e6_done"}, {31'd0, done}, 32'd0);
    check({name, "_data_hold"}, {24'd0, out_data}, 32'hB6);
    finish_burst(name, d0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int base;
    logic [AW-1:0] sa;
    logic [AW-1:0] len;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;

    tick();
    tick();
    check("rst_addr", {24'd0, rom_address}, 32'd0);
    check("rst_ce", {31'd0, rom_ce}, 32'd0);
    check("rst_read_en", {31'd0, rom_read_en}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;
    tick();

    timed_basic("basic");

    ready_mode = 2;
    tick();
    d0 = done_cnt;
    issue(8'h10, 8'd4);
    finish_burst("backpressure", d0);

    ready_mode = 1;
    d0 = done_cnt;
    issue(8'hFE, 8'd4);
    finish_burst("wrap", d0);

    ready_mode = 0;
    d0 = done_cnt;
    issue(8'h00, 8'd0);
    finish_burst("full_depth", d0);

    // abort together with start in IDLE: nothing starts
    abort = 1'b1;
    start = 1'b1;
    start_addr = 8'h20;
    length = 8'd3;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_busy", {31'd0, busy}, 32'd0);
    tick();
    check("abort_start_busy2", {31'd0, busy}, 32'd0);

    // stray start mid-burst, then abort after two accepted words
    ready_mode = 0;
    d0 = done_cnt;
    base = hs_cnt;
    issue(8'h30, 8'd10);
    start = 1'b1;
    start_addr = 8'h80;
    length = 8'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50 && (hs_cnt - base) < 2; i++) tick();
    check("abort_words_before", hs_cnt - base, 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_ce", {31'd0, rom_ce}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    flush();
    tick();
    tick();
    check("abort_no_done", done_cnt - d0, 32'd0);

    // reset mid-burst
    d0 = done_cnt;
    issue(8'h40, 8'd20);
    tick();
    tick();
    tick();
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_addr", {24'd0, rom_address}, 32'd0);
    check("mid_rst_ce", {31'd0, rom_ce}, 32'd0);
    check("mid_rst_read_en", {31'd0, rom_read_en}, 32'd0);
    check("mid_rst_data", {24'd0, out_data}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    flush();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("mid_rst_no_done", done_cnt - d0, 32'd0);
    timed_basic("post_reset");

    // randomized bursts over randomized ROM contents
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int b = 0; b < 20; b++) begin
      ready_mode = $urandom_range(0, 2);
      sa = 8'($urandom);
      len = ($urandom_range(0, 24) == 0) ? 8'd0 : 8'($urandom_range(1, 24));
      d0 = done_cnt;
      issue(sa, len);
      finish_burst("random", d0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rom_stream_reader.md
# rom_stream_reader

Sequential reader that sits directly in front of the `rom` block: it owns the ROM's address, read-enable and chip-enable inputs, and consumes the ROM's combinational data output. It fetches a burst of consecutive words from a programmed start address and presents them on a valid/ready output stream, one word per cycle under no backpressure. It stalls ROM reads while the consumer is not ready, and signals completion with a one-cycle done pulse.

## Interface
Parameters:
- `ADDR_W`, 8, ROM address width; the ROM depth is 2^ADDR_W.
- `DATA_W`, 8, ROM data width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  burst request; sampled only in IDLE.
- `start_addr`  in  ADDR_W  first address of the burst.
- `length`  in  ADDR_W  word count; 0 means 2^ADDR_W (256 by default).
- `abort`  in  1  cancels the burst in progress.
- `rom_address`  out  ADDR_W  drives ROM `address`.
- `rom_read_en`  out  1  drives ROM `read_en`.
- `rom_ce`  out  1  drives ROM `ce`.
- `rom_data`  in  DATA_W  from ROM `data`; combinational in the current address.
- `out_data`  out  DATA_W  stream word.
- `out_valid`  out  1  stream word is valid.
- `out_ready`  in  1  consumer accepts the word.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse when the last word of the burst has been accepted.

## Operation
- States: IDLE, FETCH, DRAIN.
- Internal registers: address counter `addr` (ADDR_W bits) and remaining-word counter `rem` (ADDR_W+1 bits).
- `load = (state==FETCH) && (!out_valid || out_ready)`.
- `rom_ce = rom_read_en = load`. Both are combinational from registered state and `out_ready`.
- `rom_address = addr`. It is registered and stays stable outside fetches.
- IDLE:
  - On `start && !abort`: `addr <= start_addr`; `rem <= (length==0) ? 2^ADDR_W : length`; go to FETCH.
- FETCH, on each cycle where `load` is high:
  - `out_data <= rom_data` and `out_valid <= 1`.
  - `addr <= addr+1`, modulo 2^ADDR_W; it wraps from 0xFF to 0x00 with no error.
  - `rem <= rem-1`; when `rem==1`, go to DRAIN.
- FETCH, when `load` is low and `out_valid && out_ready` (cannot happen; load covers it): no change. Stall whenever `out_valid && !out_ready`: `out_data`, `out_valid` and `addr` hold, and ROM enables are low.
- DRAIN:
  - On `out_valid && out_ready`: `out_valid <= 0`, `done <= 1` for one cycle, go to IDLE.
- Output word rules:
  - Consumption without a concurrent load clears `out_valid`.
  - Simultaneous consume and load replaces `out_data` with no bubble.
- Abort, in any non-IDLE state: next edge returns to IDLE, `out_valid <= 0`, no `done`, and the word in flight is discarded.
- `abort` together with `start` in IDLE: abort wins, `start` is ignored.
- `start` while `busy`: ignored, and it has no effect on the current burst.
- `out_data` holds its last value after the burst ends; it is not cleared.

## Timing
- Reset (async assert, sync release) values: state IDLE, `addr` 0, `rem` 0, `rom_address` 0, `rom_ce` 0, `rom_read_en` 0, `out_data` 0, `out_valid` 0, `busy` 0, `done` 0.
- Reset asserted mid-burst aborts it immediately. There is no `done` and no further ROM enables.
- Latency:
  - `start` sampled at edge E0.
  - Cycle after E0: `rom_address = start_addr`, `rom_ce = 1`.
  - After edge E0+1: `out_valid = 1` with `out_data = mem[start_addr]`.
- Throughput: with `out_ready` held high, an N-word burst produces `out_valid` for N consecutive cycles.
- `done` asserts in the cycle after the last handshake. For an unstalled burst that is E0+N+1.
- `busy` deasserts together with `done`. A new `start` is accepted in the cycle in which `done` is high.
- Handshake: `out_data` and `out_valid` must not change while `out_valid && !out_ready`.

## Test plan
- Basic burst: ROM loaded with mem[i]=i^0xA5; `start_addr`=0x10, `length`=4, `out_ready`=1 -> words 0xB5,0xB4,0xB7,0xB6 on 4 consecutive cycles starting 2 cycles after start; `done` pulses once; `busy` then 0.
- Backpressure: same burst with `out_ready` toggling 1,0,0,1,... -> no word lost or duplicated; `rom_ce` low and `rom_address` stable during stalls; `out_data` stable while not ready.
- Wrap-around: `start_addr`=0xFE, `length`=4 -> addresses 0xFE,0xFF,0x00,0x01; data matches mem at those addresses.
- Full-depth burst: `length`=0 -> exactly 256 words, addresses 0x00..0xFF in order, one `done`.
- Abort and start while busy: `start` pulsed mid-burst -> ignored. `abort` after 2 words -> IDLE next cycle, `out_valid` 0, no `done`, ROM enables low.
- Reset mid-burst: `reset_n` low mid-transfer -> all outputs at reset values immediately; a fresh `start` after release behaves as in the basic burst.
